// File: rtl/contra_sprite_pkg.sv
// Shared types and helpers for the Contra sprite fetch stages.
//   pal_idx_t        3-bit palette index
//   TRANSPARENT_IDX  palette index used as the colour key (dark green)
//   sprite_pos_t     per-frame shadow copy of an enemy's position and flags
//   in_span()        11-bit window test that cannot wrap past column/row 1023
package contra_sprite_pkg;

    typedef logic [2:0] pal_idx_t;

    localparam pal_idx_t TRANSPARENT_IDX = 3'd0;
    localparam int       SCREEN_W        = 640;
    localparam int       SCREEN_H        = 480;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       facing;
    } sprite_pos_t;

    // True when lo <= v < lo + len, evaluated one bit wider than the
    // operands so a sprite hanging off the right/bottom edge clips instead
    // of wrapping around to coordinate 0.
    function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                     input int unsigned len);
        logic [10:0] v_e;
        logic [10:0] lo_e;
        v_e  = {1'b0, v};
        lo_e = {1'b0, lo};
        return (v_e >= lo_e) && (v_e < lo_e + 11'(len));
    endfunction

endpackage

// File: rtl/sprite_anim_counter.sv
// Run-cycle animation counter shared by the enemy sprite fetch stages.
//   clk, rst     clock and synchronous active-high reset
//   frame_start  one pulse per video frame
//   active       incoming enemy_active; 0 at a frame_start restarts the cycle
//   frame        current animation frame, 0..N_FRAMES-1
// Each animation frame is shown for FRAME_HOLD frame_start pulses.
module sprite_anim_counter #(
    parameter int N_FRAMES   = 4,
    parameter int FRAME_HOLD = 6,
    parameter int FRAME_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               active,
    output logic [FRAME_W-1:0] frame
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(N_FRAMES - 1);

    logic [HOLD_W-1:0] hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame <= '0;
            hold  <= '0;
        end else if (frame_start) begin
            if (!active) begin
                // A dead enemy restarts from frame 0 when it respawns.
                frame <= '0;
                hold  <= '0;
            end else if (hold == HOLD_LAST) begin
                hold  <= '0;
                frame <= (frame == FRAME_LAST) ? '0 : frame + 1'b1;
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end

endmodule

// File: rtl/running_enemy_green_sprite_fetch.sv
// Per-pixel sprite fetch for the green running enemy (RunningR2 animation).
//   Clk, Reset     pixel clock, synchronous active-high reset
//   frame_start    1-cycle pulse at start of vertical blanking
//   enemy_x/y      sprite top-left corner, latched on frame_start
//   enemy_active   enemy visible, latched on frame_start
//   facing_left    horizontal mirror, latched on frame_start
//   DrawX/DrawY    current raster position
//   rom_addr       sprite ROM address (0 outside the sprite box)
//   rom_data       palette index returned by the ROM for rom_addr
//   pix_index      palette index for the LUT, 0 when pix_valid is low
//   pix_valid      opaque enemy pixel at this raster position
// DrawX/DrawY to pix_index/pix_valid is two clocks, one pixel per clock.
module running_enemy_green_sprite_fetch
    import contra_sprite_pkg::*;
#(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 48,
    parameter int N_FRAMES   = 4,
    parameter int FRAME_HOLD = 6,
    parameter int ADDR_W     = 13
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        enemy_x,
    input  logic [9:0]        enemy_y,
    input  logic              enemy_active,
    input  logic              facing_left,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic [ADDR_W-1:0] rom_addr,
    input  pal_idx_t          rom_data,
    output pal_idx_t          pix_index,
    output logic              pix_valid
);

    localparam int FRAME_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int FRAME_SIZE = SPR_W * SPR_H;

    sprite_pos_t        pos;
    logic [FRAME_W-1:0] frame;

    logic               hit_p0;
    logic [10:0]        col_raw_p0;
    logic [10:0]        col_p0;
    logic [10:0]        row_p0;
    logic [ADDR_W-1:0]  addr_p0;
    logic               hit_p1;
    logic               opaque_p1;

    // Shadow copy so a mid-frame position change cannot tear the sprite.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pos <= '0;
        end else if (frame_start) begin
            pos <= '{x: enemy_x, y: enemy_y, active: enemy_active, facing: facing_left};
        end
    end

    sprite_anim_counter #(
        .N_FRAMES  (N_FRAMES),
        .FRAME_HOLD(FRAME_HOLD),
        .FRAME_W   (FRAME_W)
    ) u_anim (
        .clk        (Clk),
        .rst        (Reset),
        .frame_start(frame_start),
        .active     (enemy_active),
        .frame      (frame)
    );

    // ---- stage 0: box test and ROM address ----
    always_comb begin
        hit_p0     = pos.active && in_span(DrawX, pos.x, SPR_W) && in_span(DrawY, pos.y, SPR_H);
        col_raw_p0 = {1'b0, DrawX} - {1'b0, pos.x};
        row_p0     = {1'b0, DrawY} - {1'b0, pos.y};
        col_p0     = pos.facing ? (11'(SPR_W - 1) - col_raw_p0) : col_raw_p0;
        addr_p0    = ADDR_W'(frame) * ADDR_W'(FRAME_SIZE)
                   + ADDR_W'(row_p0) * ADDR_W'(SPR_W)
                   + ADDR_W'(col_p0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            hit_p1   <= 1'b0;
        end else begin
            rom_addr <= hit_p0 ? addr_p0 : '0;
            hit_p1   <= hit_p0;
        end
    end

    // ---- stage 1: transparency key and output register ----
    assign opaque_p1 = hit_p1 && (rom_data != TRANSPARENT_IDX);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_valid <= 1'b0;
            pix_index <= '0;
        end else begin
            pix_valid <= opaque_p1;
            pix_index <= opaque_p1 ? rom_data : TRANSPARENT_IDX;
        end
    end

endmodule
